// File: rtl/plic_irq_gateway_pkg.sv
// -----------------------------------------------------------------------------
// plic_irq_gateway_pkg
//
// Shared definitions for the PLIC source-side interrupt gateway:
//   - PLIC line count and the interrupt index map for platform sources
//   - PLIC_EDGE_MASK: timers are edge-triggered, UART/GPIO are level-triggered
//   - gw_state_t: per-source gateway state
//   - id_legal(): range check for claim/complete IDs (ID 0 is reserved)
// -----------------------------------------------------------------------------
package plic_irq_gateway_pkg;

    localparam int PLIC_NUM_SOURCES = 32;

    // PLIC line assignments for the current platform sources.
    localparam int PLIC_TIMER0_INTERRUPT = 2;
    localparam int PLIC_TIMER1_INTERRUPT = 3;
    localparam int PLIC_UART_INTERRUPT   = 4;
    localparam int PLIC_GPIO_INTERRUPT   = 5;

    // Timers produce single-cycle ticks, so they must be counted as edges;
    // UART and GPIO hold their line until serviced, so they stay level.
    localparam logic [PLIC_NUM_SOURCES-1:0] PLIC_EDGE_MASK =
        (32'h1 << PLIC_TIMER0_INTERRUPT) | (32'h1 << PLIC_TIMER1_INTERRUPT);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_t;

    // An ID addresses a real source only if it is non-zero and below the
    // number of lines; line 0 is reserved by the PLIC.
    function automatic logic id_legal(input logic [31:0] id, input logic [31:0] num);
        return (id != 32'd0) && (id < num);
    endfunction

endpackage

// File: rtl/plic_irq_gateway_source.sv
// -----------------------------------------------------------------------------
// plic_gw_source
//
// One gateway source: IDLE -> PENDING -> INFLIGHT -> IDLE state machine plus a
// saturating edge counter (only meaningful when IS_EDGE is set).
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_samp      registered raw line (level arming)
//   i_rise      rising edge detected on the registered line
//   i_claim     claim addressed to this source this cycle
//   i_complete  completion addressed to this source this cycle
//   o_pending   request to the PLIC (registered)
//   o_inflight  claimed, awaiting completion (registered)
// -----------------------------------------------------------------------------
module plic_gw_source
    import plic_irq_gateway_pkg::*;
#(
    parameter bit IS_EDGE   = 1'b0,
    parameter int CNT_WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_samp,
    input  logic i_rise,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending,
    output logic o_inflight
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    gw_state_t            r_state;
    gw_state_t            w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_arm;
    logic                 w_take;
    logic                 w_inc;
    logic                 w_dec;
    logic                 w_pending_next;
    logic                 w_inflight_next;
    logic                 r_pending;
    logic                 r_inflight;

    // Level sources arm on the sampled line; edge sources arm while any
    // counted edge is still unserviced.
    assign w_arm = IS_EDGE ? (r_cnt != '0) : i_samp;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= GW_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A claim is only ever taken from PENDING and a
    // completion only from INFLIGHT, so stray events never move the state.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        case (r_state)
            GW_IDLE: begin
                if (w_arm) begin
                    w_state_next = GW_PENDING;
                end
            end
            GW_PENDING: begin
                if (i_claim) begin
                    w_state_next = GW_INFLIGHT;
                    w_take       = 1'b1;
                end
            end
            GW_INFLIGHT: begin
                if (i_complete) begin
                    w_state_next = GW_IDLE;
                end
            end
            default: begin
                w_state_next = GW_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register without a decode stage after the flops.
    always_comb begin
        w_pending_next  = (w_state_next == GW_PENDING);
        w_inflight_next = (w_state_next == GW_INFLIGHT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_inflight <= w_inflight_next;
        end
    end

    // Edge counter: an edge coinciding with its own claim nets to zero;
    // otherwise edges saturate at CNT_MAX and further edges are dropped.
    always_comb begin
        w_inc      = IS_EDGE && i_rise;
        w_dec      = IS_EDGE && w_take;
        w_cnt_next = r_cnt;
        if (w_inc && !w_dec) begin
            if (r_cnt != CNT_MAX) begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else if (!w_inc && w_dec) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_pending  = r_pending;
    assign o_inflight = r_inflight;

endmodule

// File: rtl/plic_irq_gateway.sv
// -----------------------------------------------------------------------------
// plic_irq_gateway
//
// Source-side PLIC interrupt gateway. Raw lines (by PLIC index) are sampled,
// turned into one-at-a-time requests and tracked through claim/complete.
//
// Ports:
//   clock_i           system clock
//   reset_ni          asynchronous active-low reset
//   src_irq_i         raw interrupt lines by PLIC index; bit 0 ignored
//   plic_irq_o        request to the PLIC; bit 0 tied 0
//   claim_valid_i     PLIC claimed a source this cycle
//   claim_id_i        claimed source ID
//   complete_valid_i  hart wrote completion this cycle
//   complete_id_i     completed source ID
//   inflight_o        source claimed, not yet completed
//   proto_err_o       one-cycle pulse on an illegal claim/complete
//
// Build option:
//   PLIC_GW_SYNC_EN   adds a 2-flop synchronizer per line ahead of the sample
//                     register (request latency 4 cycles instead of 2).
// -----------------------------------------------------------------------------
module plic_irq_gateway
    import plic_irq_gateway_pkg::*;
#(
    parameter int                     NUM_SOURCES    = 32,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK      = '0,
    parameter int                     EDGE_CNT_WIDTH = 4,
    parameter int                     ID_WIDTH       = $clog2(NUM_SOURCES)
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic [NUM_SOURCES-1:0] src_irq_i,
    output logic [NUM_SOURCES-1:0] plic_irq_o,
    input  logic                   claim_valid_i,
    input  logic [ID_WIDTH-1:0]    claim_id_i,
    input  logic                   complete_valid_i,
    input  logic [ID_WIDTH-1:0]    complete_id_i,
    output logic [NUM_SOURCES-1:0] inflight_o,
    output logic                   proto_err_o
);

    logic [NUM_SOURCES-1:0] w_src_in;
    logic [NUM_SOURCES-1:0] r_samp;
    logic [NUM_SOURCES-1:0] r_samp_prev;
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_pending;
    logic [NUM_SOURCES-1:0] w_inflight;
    logic [NUM_SOURCES-1:0] w_claim_sel;
    logic [NUM_SOURCES-1:0] w_complete_sel;
    logic                   w_claim_legal;
    logic                   w_complete_legal;
    logic                   w_err;
    logic                   r_proto_err;
    logic                   w_unused_src0;

    // ---------------------------------------------------------------- input
`ifdef PLIC_GW_SYNC_EN
    logic [NUM_SOURCES-1:0] r_sync1;
    logic [NUM_SOURCES-1:0] r_sync2;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_in = r_sync2;
`else
    assign w_src_in = src_irq_i;
`endif

    // Line 0 is reserved; it is never sampled.
    assign w_unused_src0 = w_src_in[0];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_samp      <= '0;
            r_samp_prev <= '0;
        end else begin
            r_samp      <= {w_src_in[NUM_SOURCES-1:1], 1'b0};
            r_samp_prev <= r_samp;
        end
    end

    assign w_rise = r_samp & ~r_samp_prev;

    // ------------------------------------------------------------ ID decode
    // Legality is judged against the current state of each source on its
    // own, so a same-ID claim+complete resolves naturally: from PENDING the
    // claim is legal and the complete is not; from INFLIGHT the reverse.
    assign w_claim_legal    = id_legal(32'(claim_id_i), 32'(NUM_SOURCES)) &&
                              w_pending[claim_id_i];
    assign w_complete_legal = id_legal(32'(complete_id_i), 32'(NUM_SOURCES)) &&
                              w_inflight[complete_id_i];

    assign w_err = (claim_valid_i && !w_claim_legal) ||
                   (complete_valid_i && !w_complete_legal);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_err;
        end
    end

    // -------------------------------------------------------------- sources
    assign w_claim_sel[0]    = 1'b0;
    assign w_complete_sel[0] = 1'b0;
    assign w_pending[0]      = 1'b0;
    assign w_inflight[0]     = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_SOURCES; gi++) begin : g_src
            // Each source only reacts to a claim in PENDING or a complete in
            // INFLIGHT, so the raw ID match is enough here.
            assign w_claim_sel[gi]    = claim_valid_i &&
                                        (claim_id_i == ID_WIDTH'(gi));
            assign w_complete_sel[gi] = complete_valid_i &&
                                        (complete_id_i == ID_WIDTH'(gi));

            plic_gw_source #(
                .IS_EDGE   (EDGE_MASK[gi]),
                .CNT_WIDTH (EDGE_CNT_WIDTH)
            ) u_src (
                .i_clk      (clock_i),
                .i_rst_n    (reset_ni),
                .i_samp     (r_samp[gi]),
                .i_rise     (w_rise[gi]),
                .i_claim    (w_claim_sel[gi]),
                .i_complete (w_complete_sel[gi]),
                .o_pending  (w_pending[gi]),
                .o_inflight (w_inflight[gi])
            );
        end
    endgenerate

    assign plic_irq_o  = w_pending;
    assign inflight_o  = w_inflight;
    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_plic_irq_gateway.sv
module tb_plic_irq_gateway;
    import plic_irq_gateway_pkg::*;

    localparam int N   = 32;
    localparam int IDW = 5;
`ifdef PLIC_GW_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic           clock_i = 1'b0;
    logic           reset_ni = 1'b0;
    logic [N-1:0]   src_irq_i = '0;
    logic [N-1:0]   plic_irq_o;
    logic           claim_valid_i = 1'b0;
    logic [IDW-1:0] claim_id_i = '0;
    logic           complete_valid_i = 1'b0;
    logic [IDW-1:0] complete_id_i = '0;
    logic [N-1:0]   inflight_o;
    logic           proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int got;

    plic_irq_gateway #(
        .NUM_SOURCES    (N),
        .EDGE_MASK      (PLIC_EDGE_MASK),
        .EDGE_CNT_WIDTH (4),
        .ID_WIDTH       (IDW)
    ) dut (
        .clock_i          (clock_i),
        .reset_ni         (reset_ni),
        .src_irq_i        (src_irq_i),
        .plic_irq_o       (plic_irq_o),
        .claim_valid_i    (claim_valid_i),
        .claim_id_i       (claim_id_i),
        .complete_valid_i (complete_valid_i),
        .complete_id_i    (complete_id_i),
        .inflight_o       (inflight_o),
        .proto_err_o      (proto_err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
        $display("[TB] %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle of claim/complete traffic, then idle the handshake inputs.
    task automatic cycle(input logic cv, input logic [IDW-1:0] cid,
                         input logic pv, input logic [IDW-1:0] pid);
        claim_valid_i    = cv;
        claim_id_i       = cid;
        complete_valid_i = pv;
        complete_id_i    = pid;
        tick;
        claim_valid_i    = 1'b0;
        claim_id_i       = '0;
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
    endtask

    initial begin
        // ---------------- reset
        repeat (2) tick;
        check("rst_plic", plic_irq_o, 32'h0);
        check("rst_inflight", inflight_o, 32'h0);
        check("rst_err", {31'b0, proto_err_o}, 32'h0);
        reset_ni = 1'b1;
        tick;

        // ---------------- level source 4
        src_irq_i[4] = 1'b1;
        repeat (LAT - 1) tick;
        check("lvl_lat_minus1", {31'b0, plic_irq_o[4]}, 32'h0);
        tick;
        check("lvl_lat", plic_irq_o, 32'h10);
        cycle(1'b1, 5'd4, 1'b0, 5'd0);
        check("lvl_claim_plic", plic_irq_o, 32'h0);
        check("lvl_claim_inflight", inflight_o, 32'h10);
        check("lvl_claim_err", {31'b0, proto_err_o}, 32'h0);
        cycle(1'b0, 5'd0, 1'b1, 5'd4);
        check("lvl_cmpl_inflight", inflight_o, 32'h0);
        check("lvl_cmpl_idle", plic_irq_o, 32'h0);
        tick;
        check("lvl_rearm", plic_irq_o, 32'h10);
        // Line drops while PENDING: request must stay until claimed.
        src_irq_i[4] = 1'b0;
        repeat (5) tick;
        check("lvl_no_retract", plic_irq_o, 32'h10);
        cycle(1'b1, 5'd4, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 1'b1, 5'd4);
        repeat (2) tick;
        check("lvl_low_no_rearm", plic_irq_o | inflight_o, 32'h0);

        // ---------------- edge source 2: 3 pulses, 3 requests
        for (int k = 0; k < 3; k++) begin
            src_irq_i[2] = 1'b1;
            tick;
            src_irq_i[2] = 1'b0;
            tick;
        end
        repeat (6) tick;
        check("edge2_req", plic_irq_o, 32'h4);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 5'd2, 1'b0, 5'd0);
            check("edge2_claim", inflight_o, 32'h4);
            cycle(1'b0, 5'd0, 1'b1, 5'd2);
            tick;
            check("edge2_rearm", {31'b0, plic_irq_o[2]}, (k < 2) ? 32'h1 : 32'h0);
        end
        repeat (3) tick;
        check("edge2_drained", plic_irq_o | inflight_o, 32'h0);

        // ---------------- edge source 3: 20 pulses saturate at 15
        for (int k = 0; k < 20; k++) begin
            src_irq_i[3] = 1'b1;
            tick;
            src_irq_i[3] = 1'b0;
            tick;
        end
        repeat (6) tick;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (plic_irq_o[3]) begin
                cycle(1'b1, 5'd3, 1'b0, 5'd0);
                cycle(1'b0, 5'd0, 1'b1, 5'd3);
                tick;
                got++;
            end else begin
                tick;
            end
        end
        check("edge3_sat_count", 32'(got), 32'd15);
        check("edge3_drained", plic_irq_o | inflight_o, 32'h0);

        // ---------------- protocol errors
        cycle(1'b0, 5'd0, 1'b1, 5'd4);
        check("err_cmpl_idle", {31'b0, proto_err_o}, 32'h1);
        tick;
        check("err_pulse_1cyc", {31'b0, proto_err_o}, 32'h0);
        check("err_no_state", plic_irq_o | inflight_o, 32'h0);
        cycle(1'b1, 5'd0, 1'b0, 5'd0);
        check("err_claim_id0", {31'b0, proto_err_o}, 32'h1);
        tick;
        check("err_id0_clear", {31'b0, proto_err_o}, 32'h0);
        cycle(1'b1, 5'd5, 1'b0, 5'd0);
        check("err_claim_idle", {31'b0, proto_err_o}, 32'h1);
        check("err_claim_nostate", plic_irq_o | inflight_o, 32'h0);

        // ---------------- simultaneous claim 2 / complete 4
        src_irq_i[4] = 1'b1;
        src_irq_i[2] = 1'b1;
        tick;
        src_irq_i[2] = 1'b0;
        repeat (6) tick;
        check("sim_both_pending", plic_irq_o, 32'h14);
        src_irq_i[4] = 1'b0;
        repeat (4) tick;
        cycle(1'b1, 5'd4, 1'b0, 5'd0);
        check("sim_4_inflight", inflight_o, 32'h10);
        check("sim_2_pending", plic_irq_o, 32'h4);
        cycle(1'b1, 5'd2, 1'b1, 5'd4);
        check("sim_inflight", inflight_o, 32'h4);
        check("sim_err", {31'b0, proto_err_o}, 32'h0);
        check("sim_plic", plic_irq_o, 32'h0);
        cycle(1'b0, 5'd0, 1'b1, 5'd2);
        repeat (2) tick;
        check("sim_drained", plic_irq_o | inflight_o, 32'h0);

        // ---------------- same-ID claim+complete
        src_irq_i[4] = 1'b1;
        repeat (LAT) tick;
        src_irq_i[4] = 1'b0;
        repeat (4) tick;
        cycle(1'b1, 5'd4, 1'b1, 5'd4);
        check("same_pend_inflight", inflight_o, 32'h10);
        check("same_pend_err", {31'b0, proto_err_o}, 32'h1);
        cycle(1'b1, 5'd4, 1'b1, 5'd4);
        check("same_infl_inflight", inflight_o, 32'h0);
        check("same_infl_err", {31'b0, proto_err_o}, 32'h1);
        repeat (2) tick;
        check("same_drained", plic_irq_o, 32'h0);

        // ---------------- reset mid-operation
        src_irq_i[4] = 1'b1;
        repeat (LAT) tick;
        cycle(1'b1, 5'd4, 1'b0, 5'd0);
        check("mid_inflight", inflight_o, 32'h10);
        src_irq_i[4] = 1'b0;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_plic", plic_irq_o, 32'h0);
        check("mid_rst_inflight", inflight_o, 32'h0);
        tick;
        reset_ni = 1'b1;
        tick;
        cycle(1'b0, 5'd0, 1'b1, 5'd4);
        check("mid_stale_cmpl_err", {31'b0, proto_err_o}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_irq_gateway.md
Name: plic_irq_gateway

Overview:
- Source-side interrupt gateway between platform interrupt producers (PBUS timers, UART, GPIO-in, future HBUS/MBUS sources) and the PLIC.
- Converts raw level or edge lines, indexed by PLIC line number, into one-at-a-time PLIC requests.
- Tracks the PLIC claim/complete handshake per source and re-arms each source on completion.
- Instantiated once in the SoC top; raw lines are wired to PLIC_*_INTERRUPT indices from the system package.

Parameters:
- NUM_SOURCES, 32, number of PLIC lines; line 0 reserved.
- EDGE_MASK, 32'h0000_0000, bit i = 1 makes source i edge-triggered; otherwise level-triggered.
- EDGE_CNT_WIDTH, 4, width of the per-source saturating edge counter.
- ID_WIDTH, $clog2(NUM_SOURCES), width of claim/complete IDs.

Ports:
- clock_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- src_irq_i  in  NUM_SOURCES  raw interrupt lines by PLIC index; bit 0 ignored
- plic_irq_o  out  NUM_SOURCES  request to PLIC; bit 0 tied 0
- claim_valid_i  in  1  PLIC claimed a source this cycle
- claim_id_i  in  ID_WIDTH  claimed source ID
- complete_valid_i  in  1  hart wrote completion this cycle
- complete_id_i  in  ID_WIDTH  completed source ID
- inflight_o  out  NUM_SOURCES  source claimed, not yet completed
- proto_err_o  out  1  one-cycle pulse on illegal claim/complete

Behaviour:
- Interface: one clock (clock_i); reset_ni is asynchronous and active-low. All outputs registered.
- Reset: plic_irq_o=0, inflight_o=0, proto_err_o=0, all FSMs IDLE, edge counters 0, sample registers 0.
- Input stage: src_irq_i is registered into samp_q. Edge sources detect a rising edge as samp_q & ~samp_prev_q.
- Per-source FSM: IDLE, PENDING, INFLIGHT.
  - IDLE -> PENDING: level source with samp_q=1, or edge source with cnt>0.
  - PENDING -> INFLIGHT: claim_valid_i with claim_id_i==i. Edge counter decrements on this transition.
  - INFLIGHT -> IDLE: complete_valid_i with complete_id_i==i.
- Outputs per source: plic_irq_o[i] = (state==PENDING); inflight_o[i] = (state==INFLIGHT).
- Latency: src rise to plic_irq_o high is 2 cycles (sample, then state).
- Level re-arm: after completion the FSM spends at least 1 cycle in IDLE. A line still high re-raises plic_irq_o 1 cycle after IDLE.
- Level deassert while PENDING: request stays asserted until claimed. The gateway never retracts a request.
- Edge counter:
  - Increments on each detected edge in any state; saturates at 2^EDGE_CNT_WIDTH-1.
  - An edge in the same cycle as its claim leaves the count unchanged (+1-1).
  - Edges beyond saturation are dropped.
- Simultaneous claim and complete for different IDs are both processed.
- Claim and complete for the same ID in the same cycle:
  - From PENDING: claim wins; the complete is an error.
  - From INFLIGHT: complete is processed; the claim is an error.
- proto_err_o pulses 1 cycle after any of:
  - claim of a source not PENDING;
  - complete of a source not INFLIGHT;
  - ID 0 or ID >= NUM_SOURCES.
  The offending event causes no state change.
- Reset asserted mid-operation returns everything to reset values immediately. In-flight claims are forgotten, and later completes for them flag proto_err_o.

Optional Feature:
- Macro: PLIC_GW_SYNC_EN.
- Defined: a 2-flop synchronizer per source precedes samp_q for asynchronous or off-domain lines. src-to-plic_irq_o latency becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: no synchronizer; latency 2 cycles. src_irq_i must be synchronous to clock_i.

Decomposition:
- System package additions:
  - PLIC_NUM_SOURCES=32.
  - PLIC_EDGE_MASK constant: timers edge-triggered, UART and GPIO level-triggered.
  - gw_state_t enum {GW_IDLE, GW_PENDING, GW_INFLIGHT}.
- Sub-module plic_gw_source: one-source FSM plus edge counter, generated NUM_SOURCES-1 times.
- Top level holds the ID decode, error detection and optional synchronizer.

Test Plan:
- Level source 4: src_irq_i[4]=1 held → plic_irq_o[4]=1 at cycle +2. Claim id 4 → plic_irq_o[4]=0, inflight_o[4]=1 next cycle. Complete id 4 with line still high → inflight_o[4]=0, then plic_irq_o[4]=1 one cycle later.
- Edge source 2, three 1-cycle pulses before any claim → one request. Claim/complete repeated 3 times → exactly 3 requests, then plic_irq_o[2] stays 0.
- Edge source 3 with EDGE_CNT_WIDTH=4 and 20 pulses → exactly 15 claimable requests.
- Complete id 4 while IDLE, and claim id 0 → proto_err_o pulses once each; no state change.
- Source 2 PENDING and source 4 INFLIGHT; claim 2 and complete 4 in the same cycle → inflight_o = bit2 only, proto_err_o=0.
- Source 4 INFLIGHT, assert reset_ni=0 for 1 cycle → all outputs 0. Complete id 4 after reset → proto_err_o=1. Repeat the level test with PLIC_GW_SYNC_EN defined → latency 4 cycles.
